// File: rtl/ifu_fetch.sv
// Instruction fetch unit: in-order bus requests, credit-limited response FIFO, jump redirect/flush.
// Optional build macro IFU_MISALIGN_CHK_EN: misaligned jump targets halt fetch and raise ifu_misalign_o.
module ifu_fetch #(
    parameter int unsigned          ADDR_W     = 32,
    parameter int unsigned          DATA_W     = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC   = '0,
    parameter int unsigned          FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_jump_flag_i,
    input  logic [ADDR_W-1:0] ifu_jump_addr_i,
    input  logic              ifu_hold_flag_i,
    output logic              ibus_req_o,
    output logic [ADDR_W-1:0] ibus_addr_o,
    input  logic              ibus_gnt_i,
    input  logic              ibus_rvalid_i,
    input  logic [DATA_W-1:0] ibus_rdata_i,
    output logic [ADDR_W-1:0] ifu_pc_o,
    output logic [DATA_W-1:0] ifu_inst_data_o,
    output logic              ifu_valid_o,
    output logic              ifu_misalign_o
);

    localparam int unsigned       PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned       CntW = PtrW + 1;
    localparam logic [DATA_W-1:0] Nop  = DATA_W'(32'h0000_0013);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHalt
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [CntW-1:0]   outst_q, outst_d;
    logic [CntW-1:0]   discard_q, discard_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [PtrW-1:0]   wptr_q, wptr_d;
    logic [PtrW-1:0]   rptr_q, rptr_d;

    logic [DATA_W-1:0] inst_mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] pc_mem_q   [FIFO_DEPTH];

    logic [ADDR_W-1:0] jump_target;
    logic              jump_misaligned;
    logic [CntW:0]     inflight;
    logic              credit_ok;
    logic              grant;
    logic              drop;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic [ADDR_W-1:0] resp_pc;

`ifdef IFU_MISALIGN_CHK_EN
    logic misalign_q, misalign_d;

    assign jump_target     = ifu_jump_addr_i;
    assign jump_misaligned = ifu_jump_flag_i & (ifu_jump_addr_i[1:0] != 2'b00);
    assign ifu_misalign_o  = misalign_q;
`else
    logic unused_jump_lsb;

    assign unused_jump_lsb = ^ifu_jump_addr_i[1:0];
    assign jump_target     = {ifu_jump_addr_i[ADDR_W-1:2], 2'b00};
    assign jump_misaligned = 1'b0;
    assign ifu_misalign_o  = 1'b0;
`endif

    // Stale responses still count against the credit until they drain.
    assign inflight   = {1'b0, outst_q} + {1'b0, count_q};
    assign credit_ok  = inflight < (CntW + 1)'(FIFO_DEPTH);
    assign fifo_empty = (count_q == '0);

    assign ibus_req_o  = (state_q == StRun) && credit_ok && !ifu_jump_flag_i;
    assign ibus_addr_o = fetch_pc_q;

    assign grant = ibus_req_o & ibus_gnt_i;
    assign drop  = ibus_rvalid_i & (discard_q != '0);
    assign push  = ibus_rvalid_i & !drop & !ifu_jump_flag_i;
    assign pop   = !fifo_empty & !ifu_hold_flag_i & !ifu_jump_flag_i;

    // Once no stale responses remain, every outstanding request is live and contiguous, so the
    // oldest one sits outstanding words behind the next fetch address.
    assign resp_pc = fetch_pc_q - ADDR_W'({outst_q, 2'b00});

    assign ifu_valid_o     = !fifo_empty;
    assign ifu_pc_o        = fifo_empty ? '0  : pc_mem_q[rptr_q];
    assign ifu_inst_data_o = fifo_empty ? Nop : inst_mem_q[rptr_q];

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q + CntW'(grant) - CntW'(ibus_rvalid_i);
        discard_d  = discard_q;
        count_d    = count_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
`ifdef IFU_MISALIGN_CHK_EN
        misalign_d = misalign_q;
`endif

        unique case (state_q)
            StIdle:        state_d = StRun;
            StRun, StHalt: begin
                if (ifu_jump_flag_i) begin
                    state_d = jump_misaligned ? StHalt : StRun;
                end
            end
            default:       state_d = StIdle;
        endcase

        if (ifu_jump_flag_i) begin
            // Everything still in flight belongs to the old path.
            discard_d  = outst_q - CntW'(ibus_rvalid_i);
            fetch_pc_d = jump_target;
            count_d    = '0;
            wptr_d     = '0;
            rptr_d     = '0;
`ifdef IFU_MISALIGN_CHK_EN
            misalign_d = jump_misaligned;
`endif
        end else begin
            discard_d = discard_q - CntW'(drop);
            if (grant) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(4);
            end
            if (push) begin
                wptr_d = wptr_q + PtrW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
`ifdef IFU_MISALIGN_CHK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
`ifdef IFU_MISALIGN_CHK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem_q[wptr_q] <= ibus_rdata_i;
            pc_mem_q[wptr_q]   <= resp_pc;
        end
    end

`ifndef SYNTHESIS
    a_rvalid_with_outstanding: assert property (
        @(posedge clk) disable iff (rst) ibus_rvalid_i |-> (outst_q != '0)
    );
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: a bus memory model with variable latency feeds the DUT and
// the expected {pc, inst} stream is queued at grant time and checked as instructions are consumed.
module tb_ifu_fetch;

    localparam logic [31:0] Nop = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_jump_flag_i;
    logic [31:0] ifu_jump_addr_i;
    logic        ifu_hold_flag_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;
    logic [31:0] ifu_pc_o;
    logic [31:0] ifu_inst_data_o;
    logic        ifu_valid_o;
    logic        ifu_misalign_o;

    ifu_fetch #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .RESET_PC  (32'h0),
        .FIFO_DEPTH(2)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_jump_flag_i(ifu_jump_flag_i),
        .ifu_jump_addr_i(ifu_jump_addr_i),
        .ifu_hold_flag_i(ifu_hold_flag_i),
        .ibus_req_o     (ibus_req_o),
        .ibus_addr_o    (ibus_addr_o),
        .ibus_gnt_i     (ibus_gnt_i),
        .ibus_rvalid_i  (ibus_rvalid_i),
        .ibus_rdata_i   (ibus_rdata_i),
        .ifu_pc_o       (ifu_pc_o),
        .ifu_inst_data_o(ifu_inst_data_o),
        .ifu_valid_o    (ifu_valid_o),
        .ifu_misalign_o (ifu_misalign_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    mem_req_t    mem_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic        jump_v, hold_v, gnt_v;
    logic [31:0] jaddr_v;
    int          lat_v;

    logic        obs_valid, obs_req, obs_grant, obs_misalign;
    logic [31:0] obs_pc, obs_inst, obs_addr;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5EED_0003;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req"},      64'(ibus_req_o),      64'(0));
        check_eq({tag, "_addr"},     64'(ibus_addr_o),     64'(32'h0));
        check_eq({tag, "_valid"},    64'(ifu_valid_o),     64'(0));
        check_eq({tag, "_pc"},       64'(ifu_pc_o),        64'(0));
        check_eq({tag, "_inst"},     64'(ifu_inst_data_o), 64'(Nop));
        check_eq({tag, "_misalign"}, 64'(ifu_misalign_o),  64'(0));
    endtask

    // Reset is held across one rising edge; outputs are checked, then reset drops for the
    // following edge, which moves the DUT out of idle.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst             = 1'b1;
        jump_v          = 1'b0;
        hold_v          = 1'b0;
        gnt_v           = 1'b1;
        ifu_jump_flag_i = 1'b0;
        ifu_hold_flag_i = 1'b0;
        ibus_gnt_i      = 1'b1;
        ibus_rvalid_i   = 1'b0;
        ibus_rdata_i    = '0;
        mem_q.delete();
        exp_q.delete();
        exp_addr = 32'h0;
        @(negedge clk);
        #1;
        check_reset_outputs(tag);
        rst = 1'b0;
    endtask

    task automatic cycle();
        @(negedge clk);
        cyc++;
        ifu_jump_flag_i = jump_v;
        ifu_jump_addr_i = jaddr_v;
        ifu_hold_flag_i = hold_v;
        ibus_gnt_i      = gnt_v;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            ibus_rvalid_i = 1'b1;
            ibus_rdata_i  = inst_of(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            ibus_rvalid_i = 1'b0;
            ibus_rdata_i  = '0;
        end
        #1;
        obs_valid    = ifu_valid_o;
        obs_pc       = ifu_pc_o;
        obs_inst     = ifu_inst_data_o;
        obs_req      = ibus_req_o;
        obs_addr     = ibus_addr_o;
        obs_grant    = ibus_req_o && ibus_gnt_i;
        obs_misalign = ifu_misalign_o;

        if (obs_req) check_eq("req_addr", 64'(obs_addr), 64'(exp_addr));
        if (jump_v)  check_eq("req_on_jump", 64'(obs_req), 64'(0));
        if (!obs_valid) check_eq("idle_nop", 64'(obs_inst), 64'(Nop));
        if (obs_valid && !jump_v) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_unexpected_valid", 64'(obs_valid), 64'(0));
            end else begin
                check_eq("sb_pc",   64'(obs_pc),   64'(exp_q[0]));
                check_eq("sb_inst", 64'(obs_inst), 64'(inst_of(exp_q[0])));
                if (!hold_v) void'(exp_q.pop_front());
            end
        end

        if (jump_v) begin
            exp_q.delete();
            exp_addr = jaddr_v;
`ifndef IFU_MISALIGN_CHK_EN
            exp_addr[1:0] = 2'b00;
`endif
        end else if (obs_grant) begin
            exp_q.push_back(exp_addr);
            exp_addr = exp_addr + 32'd4;
            mem_q.push_back('{addr: obs_addr, due: cyc + lat_v});
        end
    endtask

    // Runs until a valid instruction appears; an expired budget counts as a miscompare.
    task automatic wait_valid(input string tag, input int budget, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            cycle();
            seen = obs_valid;
        end
        check_eq({tag, "_seen"}, 64'(seen), 64'(1));
    endtask

    initial begin
        int          first;
        int          grants;
        logic        seen;
        logic [31:0] stall_addr;

        rst     = 1'b1;
        jump_v  = 1'b0;
        hold_v  = 1'b0;
        gnt_v   = 1'b1;
        jaddr_v = '0;
        lat_v   = 1;
        ifu_jump_addr_i = '0;

        // Reset and steady fetch with a one-cycle memory.
        do_reset("rst0");
        first = 0;
        for (int i = 1; i <= 12; i++) begin
            cycle();
            if (obs_valid && first == 0) begin
                first = i;
                check_eq("t1_first_pc", 64'(obs_pc), 64'(0));
            end
        end
        check_eq("t1_first_valid_cycle", 64'(first), 64'(3));

        // Grant withheld: request and address stay put, output drains to NOP.
        gnt_v = 1'b0;
        repeat (4) cycle();
        stall_addr = exp_addr;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("t4_req",   64'(obs_req),   64'(1));
            check_eq("t4_addr",  64'(obs_addr),  64'(stall_addr));
            check_eq("t4_valid", 64'(obs_valid), 64'(0));
        end
        gnt_v = 1'b1;

        // Two requests outstanding on a slow memory, then redirect.
        lat_v  = 3;
        grants = 0;
        cycle(); grants += int'(obs_grant);
        cycle(); grants += int'(obs_grant);
        check_eq("t3_grants_before_jump", 64'(grants), 64'(2));
        jump_v  = 1'b1;
        jaddr_v = 32'h100;
        cycle();
        jump_v = 1'b0;
        lat_v  = 1;
        wait_valid("t3", 20, seen);
        check_eq("t3_first_pc", 64'(obs_pc), 64'(32'h100));
        repeat (4) cycle();

        // Misaligned redirect, then an aligned one.
        jump_v  = 1'b1;
        jaddr_v = 32'h102;
        cycle();
        jump_v = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("t5_misalign", 64'(obs_misalign), 64'(1));
            check_eq("t5_halt_req", 64'(obs_req),      64'(0));
            check_eq("t5_halt_vld", 64'(obs_valid),    64'(0));
        end
`else
        wait_valid("t5_masked", 20, seen);
        check_eq("t5_masked_pc", 64'(obs_pc),       64'(32'h100));
        check_eq("t5_misalign",  64'(obs_misalign), 64'(0));
`endif
        jump_v  = 1'b1;
        jaddr_v = 32'h200;
        cycle();
        jump_v = 1'b0;
        cycle();
        check_eq("t5_misalign_clr", 64'(obs_misalign), 64'(0));
        check_eq("t5_req_200",      64'(obs_req),      64'(1));
        check_eq("t5_addr_200",     64'(obs_addr),     64'(32'h200));
        wait_valid("t5_resume", 20, seen);
        check_eq("t5_resume_pc", 64'(obs_pc), 64'(32'h200));

        // Hold from reset: fetch stops at the credit limit, nothing lost on release.
        do_reset("rst1");
        hold_v = 1'b1;
        grants = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            grants += int'(obs_grant);
        end
        check_eq("t2_grants_in_hold", 64'(grants),  64'(2));
        check_eq("t2_req_stopped",    64'(obs_req), 64'(0));
        hold_v = 1'b0;
        cycle();
        check_eq("t2_pc0", 64'(obs_pc), 64'(32'h0));
        cycle();
        check_eq("t2_pc4", 64'(obs_pc), 64'(32'h4));
        repeat (4) cycle();

        // Reset with the buffer full.
        hold_v = 1'b1;
        repeat (4) cycle();
        check_eq("t6_full_valid", 64'(obs_valid), 64'(1));
        do_reset("t6");
        repeat (10) cycle();

        // Random hold, grant, latency and occasional aligned redirects.
        for (int i = 0; i < 300; i++) begin
            hold_v  = ($urandom_range(0, 2) == 0);
            gnt_v   = ($urandom_range(0, 3) != 0);
            lat_v   = int'($urandom_range(1, 3));
            jump_v  = ($urandom_range(0, 15) == 0);
            jaddr_v = 32'($urandom_range(0, 1023)) << 2;
            cycle();
        end
        jump_v = 1'b0;
        hold_v = 1'b0;
        gnt_v  = 1'b1;
        lat_v  = 1;
        repeat (10) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
